// File: rtl/mem_readout_pkg.sv
// Shared types and default widths for the memory readout streamer.
// Imported by the streamer top and its testbench.
package mem_readout_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } readout_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-low reset.
// Brings asynchronous GPIO inputs into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/mem_readout_streamer.sv
// Walks a block of consecutive read-port addresses and ships each word to the
// host over a four-phase req/ack handshake on the GPIO header.
module mem_readout_streamer
    import mem_readout_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int WAIT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    readout_state_t    state_r,      state_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nxt_s;
    logic [DATA_W-1:0] tx_data_r,    tx_data_nxt_s;
    logic              tx_req_r,     tx_req_nxt_s;
    logic              busy_r,       busy_nxt_s;
    logic              done_r,       done_nxt_s;
    logic [CNT_W-1:0]  words_sent_r, words_sent_nxt_s;
    logic [CNT_W-1:0]  remaining_r,  remaining_nxt_s;
    logic [WAIT_W-1:0] wait_r,       wait_nxt_s;
    logic              ack_s;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_ack),
        .q   (ack_s)
    );

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            mem_addr_r   <= {ADDR_W{1'b0}};
            tx_data_r    <= {DATA_W{1'b0}};
            tx_req_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            words_sent_r <= {CNT_W{1'b0}};
            remaining_r  <= {CNT_W{1'b0}};
            wait_r       <= {WAIT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            tx_data_r    <= tx_data_nxt_s;
            tx_req_r     <= tx_req_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            words_sent_r <= words_sent_nxt_s;
            remaining_r  <= remaining_nxt_s;
            wait_r       <= wait_nxt_s;
        end
    end

    // Next-state and datapath updates for the readout sequencer
    always_comb begin
        state_nxt_s      = state_r;
        mem_addr_nxt_s   = mem_addr_r;
        tx_data_nxt_s    = tx_data_r;
        tx_req_nxt_s     = tx_req_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = 1'b0;
        words_sent_nxt_s = words_sent_r;
        remaining_nxt_s  = remaining_r;
        wait_nxt_s       = wait_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    words_sent_nxt_s = {CNT_W{1'b0}};
                    if (count != {CNT_W{1'b0}}) begin
                        mem_addr_nxt_s  = base_addr;
                        remaining_nxt_s = count;
                        busy_nxt_s      = 1'b1;
                        wait_nxt_s      = WAIT_W'(READ_LAT);
                        state_nxt_s     = WAIT;
                    end else begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            // mem_q is valid once the latency counter has run out
            WAIT: begin
                if (wait_r == {WAIT_W{1'b0}}) begin
                    tx_data_nxt_s = mem_q;
                    tx_req_nxt_s  = 1'b1;
                    state_nxt_s   = REQ;
                end else begin
                    wait_nxt_s  = wait_r - WAIT_W'(1);
                    state_nxt_s = WAIT;
                end
            end

            REQ: begin
                if (ack_s) begin
                    tx_req_nxt_s     = 1'b0;
                    words_sent_nxt_s = words_sent_r + CNT_W'(1);
                    state_nxt_s      = RELEASE;
                end else begin
                    state_nxt_s = REQ;
                end
            end

            // The host must drop ack before the next word is fetched
            RELEASE: begin
                if (!ack_s) begin
                    if (remaining_r > CNT_W'(1)) begin
                        mem_addr_nxt_s  = mem_addr_r + ADDR_W'(1);
                        remaining_nxt_s = remaining_r - CNT_W'(1);
                        wait_nxt_s      = WAIT_W'(READ_LAT);
                        state_nxt_s     = WAIT;
                    end else begin
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = RELEASE;
                end
            end

            default: begin
                state_nxt_s  = IDLE;
                tx_req_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    assign mem_addr   = mem_addr_r;
    assign tx_data    = tx_data_r;
    assign tx_req     = tx_req_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign words_sent = words_sent_r;

endmodule
